// File: rtl/sum_accumulator.sv
// Frame accumulator: sums COUNT unsigned samples into a saturating ACC_WIDTH total
// and holds each frame result in a one-entry registered output slot.
module sum_accumulator #(
    parameter int WIDTH     = 40,
    parameter int ACC_WIDTH = 48,
    parameter int COUNT     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat
);
    localparam int            CW   = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    logic [ACC_WIDTH-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 sat;

    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] result;
    logic                 sat_nxt;
    logic                 last;
    logic                 take;

    assign sum     = {1'b0, acc} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_data};
    assign result  = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
    assign sat_nxt = sat | sum[ACC_WIDTH];
    assign last    = (cnt == LAST);

    // Stall only when the frame would complete into an occupied output slot;
    // depends on registered state only, so no path from out_ready or in_valid.
    assign in_ready = !clear && !(last && out_valid);
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (take) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
                sat <= 1'b0;
            end else begin
                acc <= result;
                cnt <= cnt + CW'(1);
                sat <= sat_nxt;
            end
        end
    end

    // A load and a transfer never coincide: take && last implies the slot is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (take && last) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_sat   <= sat_nxt;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: table-driven frame/clear/backpressure rows,
// plus hand sequences for async reset mid-frame and saturation at ACC_WIDTH=41.
module tb_sum_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic [39:0] in_data = '0;

    logic        a_ir, a_ov, a_sat;
    logic [47:0] a_od;
    logic        b_ir, b_ov, b_sat;
    logic [40:0] b_od;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.WIDTH(40), .ACC_WIDTH(48), .COUNT(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data),
        .clear(clear), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .out_sat(a_sat)
    );

    sum_accumulator #(.WIDTH(40), .ACC_WIDTH(41), .COUNT(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data),
        .clear(clear), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .out_sat(b_sat)
    );

    typedef struct {
        logic        iv;
        logic [39:0] d;
        logic        clr;
        logic        ordy;
        logic        eir;
        logic        eov;
        logic [47:0] eod;
        logic        esat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, input logic [39:0] d, input logic clr,
                                input logic ordy, input logic eir, input logic eov,
                                input logic [47:0] eod, input logic esat);
        vec_t v;
        v.iv = iv; v.d = d; v.clr = clr; v.ordy = ordy;
        v.eir = eir; v.eov = eov; v.eod = eod; v.esat = esat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [39:0] d, input logic clr, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        clear     = clr;
        out_ready = ordy;
    endtask

    initial begin
        // basic frame, out_ready high: 1+2+3+4 = 10, valid for one cycle
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 2, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 4, 0, 1, 1, 1, 10, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 10, 0));
        // clear mid-frame drops partial 5,6 and the sample offered during clear
        vecs.push_back(mk(1, 5, 0, 1, 1, 0, 10, 0));
        vecs.push_back(mk(1, 6, 0, 1, 1, 0, 10, 0));
        vecs.push_back(mk(1, 7, 1, 1, 0, 0, 10, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 10, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 10, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 10, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 4, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 4, 0));
        // backpressure: frame of 1s held, second frame of 2s stalls on its last sample
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 4, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 4, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 4, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 4, 0));
        vecs.push_back(mk(1, 2, 0, 0, 1, 1, 4, 0));
        vecs.push_back(mk(1, 2, 0, 0, 1, 1, 4, 0));
        vecs.push_back(mk(1, 2, 0, 0, 1, 1, 4, 0));
        vecs.push_back(mk(1, 2, 0, 0, 0, 1, 4, 0));
        vecs.push_back(mk(1, 2, 0, 1, 0, 0, 4, 0));
        vecs.push_back(mk(1, 2, 0, 0, 1, 1, 8, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 8, 0));
        // clear with output pending: 10 held, partial 5 discarded, new frame of 1s = 4
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 8, 0));
        vecs.push_back(mk(1, 2, 0, 0, 1, 0, 8, 0));
        vecs.push_back(mk(1, 3, 0, 0, 1, 0, 8, 0));
        vecs.push_back(mk(1, 4, 0, 0, 1, 1, 10, 0));
        vecs.push_back(mk(1, 5, 0, 0, 1, 1, 10, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 10, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 10, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 10, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 10, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 10, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 10, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 4, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 4, 0));

        // reset state
        #2;
        chk("reset_out", {a_ov, a_sat, a_od}, {1'b0, 1'b0, 48'h0});
        chk("reset_in_ready", a_ir, 1);
        #10;
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].clr, vecs[i].ordy);
            #1;
            chk($sformatf("row%0d_in_ready", i), a_ir, vecs[i].eir);
            step();
            chk($sformatf("row%0d_out", i), {a_ov, a_sat, a_od},
                {vecs[i].eov, vecs[i].esat, vecs[i].eod});
        end

        // async reset mid-frame with an output pending
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, 0);
            step();
        end
        drive(1, 3, 0, 0);
        step();
        step();
        drive(0, 0, 0, 0);
        chk("pre_reset_pending", {a_ov, a_od}, {1'b1, 48'd4});
        rst = 1'b0;
        #1;
        chk("async_reset_out", {a_ov, a_sat, a_od}, {1'b0, 1'b0, 48'h0});
        chk("async_reset_in_ready", a_ir, 1);
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, 1);
            step();
        end
        chk("post_reset_frame", {a_ov, a_sat, a_od}, {1'b1, 1'b0, 48'd4});
        drive(0, 0, 0, 1);
        step();
        chk("post_reset_drain", a_ov, 0);

        // saturation on the 41-bit instance; the 48-bit one must not saturate
        for (int k = 0; k < 4; k++) begin
            drive(1, 40'hFF_FFFF_FFFF, 0, 1);
            step();
        end
        chk("sat_b_out", {b_ov, b_sat, b_od}, {1'b1, 1'b1, 41'h1FF_FFFF_FFFF});
        chk("nosat_a_out", {a_ov, a_sat, a_od}, {1'b1, 1'b0, 48'h3FF_FFFF_FFFC});
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, 1);
            step();
        end
        chk("sat_cleared_b_out", {b_ov, b_sat, b_od}, {1'b1, 1'b0, 41'd4});
        drive(0, 0, 0, 1);
        step();
        chk("sat_b_drain", b_ov, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the registered adder's sum stream. Accepts WIDTH-bit sums over a valid/ready handshake and accumulates COUNT consecutive samples into an ACC_WIDTH-bit unsigned total with saturation. Presents each completed frame total on a one-entry registered output with its own valid/ready handshake, applying backpressure upstream only when a frame completes while the previous total is still unaccepted.

## Interface
- WIDTH, 40, input sample width; matches the adder's output width.
- ACC_WIDTH, 48, accumulator and output width; ACC_WIDTH >= WIDTH is required.
- COUNT, 4, samples per frame; COUNT >= 1 is required.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  WIDTH  unsigned sample.
- clear  input  1  synchronous frame flush.
- out_valid  output  1  out_data and out_sat hold a completed frame.
- out_ready  input  1  downstream accepts the output this cycle.
- out_data  output  ACC_WIDTH  frame total.
- out_sat  output  1  the frame total saturated.

## Operation
- State: acc[ACC_WIDTH-1:0], sample counter cnt (0..COUNT-1), sticky sat flag, output register (out_valid, out_data, out_sat).
- Accept: when in_valid && in_ready, the sample is taken at the rising edge.
- Add rule: sum = acc + zero-extend(in_data), computed at ACC_WIDTH+1 bits.
  - If bit ACC_WIDTH is set, the result is all-ones and sat is set.
  - sat also stays set once set within a frame.
- Non-final sample (cnt < COUNT-1): acc <= result, cnt <= cnt+1.
- Final sample (cnt == COUNT-1):
  - out_data <= result, out_sat <= the sat value including this sample, out_valid <= 1.
  - acc, cnt and sat return to 0.
- in_ready = !clear && !(cnt == COUNT-1 && out_valid).
  - There is no combinational path from out_ready or in_valid to in_ready.
  - With COUNT=1 this reduces to in_ready = !clear && !out_valid.
- Output transfer: when out_valid && out_ready, out_valid <= 0 at the edge. out_data and out_sat keep their last values.
  - The output cannot be reloaded in the same edge, because in_ready is low on a final sample while out_valid is high.
- clear (sync):
  - acc, cnt and sat are set to 0 and the partial frame is discarded.
  - in_ready is low, so no sample is accepted that cycle.
  - A pending output is unaffected and still follows the handshake.
- Reset (async, any time, including mid-frame or with output pending): acc=0, cnt=0, sat=0, out_valid=0, out_data=0, out_sat=0. in_ready=1 whenever clear is low.

## Timing
- Latency: a final sample accepted at edge k gives out_valid=1 and a valid out_data immediately after edge k.
- Throughput: one sample per cycle while the output keeps up.
- Output held, next frame reaches its final sample: in_ready stays low until the cycle after out_valid && out_ready. This costs one bubble cycle.
- out_valid, out_data and out_sat are stable while out_valid && !out_ready.
- Reset deassertion: first accept is possible at the first rising edge with rst high.

## Test plan
- Reset: drive rst low mid-frame with 2 samples accepted and out_valid=1 -> out_valid=0, out_data=0, out_sat=0, in_ready=1. Then samples 1,1,1,1 -> out_data=4.
- Basic frame: out_ready=1, samples 1,2,3,4 back-to-back -> in_ready stays 1, out_valid high for exactly one cycle after the 4th accept, out_data=10, out_sat=0.
- Saturation: ACC_WIDTH=41, samples 0xFFFFFFFFFF x4 -> out_data=0x1FFFFFFFFFF, out_sat=1. The next frame 1,1,1,1 -> out_data=4, out_sat=0.
- Backpressure: out_ready=0, stream frame 1,1,1,1 then 2,2,2,2.
  - out_data=4 is held.
  - in_ready drops once cnt=3 of the second frame.
  - Raise out_ready for 1 cycle -> 4 is transferred, the final 2 is accepted next, out_data=8.
- Clear mid-frame: samples 5,6, then clear for 1 cycle with in_valid=1 -> in_ready=0 during clear, sample dropped. Then 1,1,1,1 -> out_data=4.
- Clear with output pending: out_ready=0, out_valid=1 with out_data=10, pulse clear -> out_data stays 10 until accepted; the partial frame restarts from 0.
